// File: rtl/ps2_pkg.sv
// Shared key codes and types for the PS/2 keyboard line editor and interpreter.
// Pure declarations: no logic, no latency.
// No flow control here; consumers decide how classes are acted upon.
package ps2_pkg;

  localparam logic [7:0] KEY_ENTER = 8'h0A;
  localparam logic [7:0] KEY_CR    = 8'h0D;
  localparam logic [7:0] KEY_BKSP  = 8'h08;
  localparam logic [7:0] KEY_ESC   = 8'h1B;
  localparam logic [7:0] PRINT_LO  = 8'h20;
  localparam logic [7:0] PRINT_HI  = 8'h7E;

  // Output slot occupancy; FULL is exactly "line_valid is high".
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;

  // One-hot key class; all zero means the code is ignored.
  typedef struct packed {
    logic enter;
    logic bksp;
    logic esc;
    logic print;
  } key_class_t;

endpackage

// File: rtl/ps2_key_classify.sv
// Maps a decoded key code to a one-hot key class (enter/bksp/esc/print).
// Purely combinational, zero latency.
// No backpressure; the caller qualifies the result with its own strobe.
module ps2_key_classify
  import ps2_pkg::*;
#(
  parameter int CHAR_W = 8  // codes above 8 bits compare as zero-extended ASCII
) (
  input  logic [CHAR_W-1:0] ascii_char,
  output key_class_t        key_class
);

  // Control codes are matched exactly; PRINT is the inclusive ASCII printable range.
  always_comb begin
    key_class       = '0;
    key_class.enter = (ascii_char == CHAR_W'(KEY_ENTER)) || (ascii_char == CHAR_W'(KEY_CR));
    key_class.bksp  = (ascii_char == CHAR_W'(KEY_BKSP));
    key_class.esc   = (ascii_char == CHAR_W'(KEY_ESC));
    key_class.print = (ascii_char >= CHAR_W'(PRINT_LO)) && (ascii_char <= CHAR_W'(PRINT_HI));
  end

endmodule

// File: rtl/ps2_line_editor.sv
// Keyboard line editor: builds a live line from key strobes and commits it on Enter.
// Latency 1: every key effect and the line_valid rise appear the cycle after the strobe.
// One-entry output slot drained by line_valid/line_ready; Enter into a busy slot pulses commit_busy.
module ps2_line_editor
  import ps2_pkg::*;
#(
  parameter int MAX_CHARS = 32,
  parameter int CHAR_W    = 8,
  parameter int LEN_W     = $clog2(MAX_CHARS + 1)
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        key_pressed,
  input  logic [CHAR_W-1:0]           ascii_char,
  output logic [MAX_CHARS*CHAR_W-1:0] live_line,
  output logic [LEN_W-1:0]            live_len,
  output logic [MAX_CHARS*CHAR_W-1:0] line_out,
  output logic [LEN_W-1:0]            line_len,
  output logic                        line_valid,
  input  logic                        line_ready,
  output logic                        overflow,
  output logic                        commit_busy
);

  localparam int              LINE_W  = MAX_CHARS * CHAR_W;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_CHARS);

  key_class_t key_class;

  logic [LINE_W-1:0] live_q, live_d;
  logic [LEN_W-1:0]  live_len_q, live_len_d;
  logic [LINE_W-1:0] line_out_q, line_out_d;
  logic [LEN_W-1:0]  line_len_q, line_len_d;
  slot_state_e       slot_q, slot_d;
  logic              overflow_q, overflow_d;
  logic              commit_busy_q, commit_busy_d;
  logic              handshake;
  logic              slot_free;

  ps2_key_classify #(
    .CHAR_W(CHAR_W)
  ) u_classify (
    .ascii_char(ascii_char),
    .key_class (key_class)
  );

  // A draining slot counts as free so Enter can reload it in the same cycle.
  assign handshake = (slot_q == SLOT_FULL) && line_ready;
  assign slot_free = (slot_q == SLOT_EMPTY) || handshake;

  // Next-state for the live line, the output slot and the one-cycle status pulses.
  always_comb begin
    live_d        = live_q;
    live_len_d    = live_len_q;
    line_out_d    = line_out_q;
    line_len_d    = line_len_q;
    slot_d        = handshake ? SLOT_EMPTY : slot_q;
    overflow_d    = 1'b0;
    commit_busy_d = 1'b0;

    if (key_pressed) begin
      if (key_class.print) begin
        if (live_len_q != LEN_MAX) begin
          // Char 0 lives in the MSBs, so slot n sits (MAX_CHARS-1-n) chars up from bit 0.
          live_d[(MAX_CHARS - 1 - int'(live_len_q)) * CHAR_W +: CHAR_W] = ascii_char;
          live_len_d = live_len_q + LEN_W'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end else if (key_class.bksp) begin
        if (live_len_q != '0) begin
          // Slot live_len-1 is MAX_CHARS-live_len chars up from bit 0.
          live_d[(MAX_CHARS - int'(live_len_q)) * CHAR_W +: CHAR_W] = '0;
          live_len_d = live_len_q - LEN_W'(1);
        end
      end else if (key_class.esc) begin
        live_d     = '0;
        live_len_d = '0;
      end else if (key_class.enter) begin
        if (slot_free) begin
          line_out_d = live_q;
          line_len_d = live_len_q;
          slot_d     = SLOT_FULL;
          live_d     = '0;
          live_len_d = '0;
        end else begin
          commit_busy_d = 1'b1;
        end
      end
    end
  end

  // State registers; reset drops any partial or pending line without committing it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      live_q        <= '0;
      live_len_q    <= '0;
      line_out_q    <= '0;
      line_len_q    <= '0;
      slot_q        <= SLOT_EMPTY;
      overflow_q    <= 1'b0;
      commit_busy_q <= 1'b0;
    end else begin
      live_q        <= live_d;
      live_len_q    <= live_len_d;
      line_out_q    <= line_out_d;
      line_len_q    <= line_len_d;
      slot_q        <= slot_d;
      overflow_q    <= overflow_d;
      commit_busy_q <= commit_busy_d;
    end
  end

  // line_valid comes straight from a flop, so line_ready never reaches it combinationally.
  assign live_line   = live_q;
  assign live_len    = live_len_q;
  assign line_out    = line_out_q;
  assign line_len    = line_len_q;
  assign line_valid  = (slot_q == SLOT_FULL);
  assign overflow    = overflow_q;
  assign commit_busy = commit_busy_q;

endmodule

// File: tb/tb_ps2_line_editor.sv
module tb_ps2_line_editor;

  logic       clock;
  logic       resetn;
  logic       key_pressed;
  logic [7:0] ascii_char;
  logic       line_ready;

  logic [255:0] live_line, line_out;
  logic [5:0]   live_len, line_len;
  logic         line_valid, overflow, commit_busy;

  logic [31:0]  live_line4, line_out4;
  logic [2:0]   live_len4, line_len4;
  logic         line_valid4, overflow4, commit_busy4;

  int n_vec = 0;
  int n_err = 0;

  ps2_line_editor #(.MAX_CHARS(32), .CHAR_W(8)) dut (
    .clock(clock), .resetn(resetn), .key_pressed(key_pressed), .ascii_char(ascii_char),
    .live_line(live_line), .live_len(live_len), .line_out(line_out), .line_len(line_len),
    .line_valid(line_valid), .line_ready(line_ready), .overflow(overflow), .commit_busy(commit_busy)
  );

  ps2_line_editor #(.MAX_CHARS(4), .CHAR_W(8)) dut4 (
    .clock(clock), .resetn(resetn), .key_pressed(key_pressed), .ascii_char(ascii_char),
    .live_line(live_line4), .live_len(live_len4), .line_out(line_out4), .line_len(line_len4),
    .line_valid(line_valid4), .line_ready(line_ready), .overflow(overflow4), .commit_busy(commit_busy4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          kp;
    byte unsigned ch;
    bit          rdy;
    int          live_len;
    logic [31:0] live_top;
    int          line_len;
    logic [31:0] out_top;
    bit          vld;
    bit          ovf;
    bit          busy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit kp, byte unsigned ch, bit rdy, int ll, logic [31:0] lt,
                              int ol, logic [31:0] ot, bit vld, bit ovf, bit busy);
    vec_t v;
    v.kp = kp; v.ch = ch; v.rdy = rdy; v.live_len = ll; v.live_top = lt;
    v.line_len = ol; v.out_top = ot; v.vld = vld; v.ovf = ovf; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit kp, input byte unsigned ch, input bit rdy);
    @(negedge clock);
    key_pressed = kp;
    ascii_char  = ch;
    line_ready  = rdy;
    @(posedge clock);
    #1;
  endtask

  // Reference: a line is a queue of chars, packed char 0 first into the MSBs.
  function automatic logic [255:0] pack(input byte unsigned q[$], input int maxc);
    logic [255:0] r;
    r = '0;
    foreach (q[i]) r[(maxc - 1 - i) * 8 +: 8] = q[i];
    return r;
  endfunction

  task automatic model_step(input int maxc, input bit kp, input byte unsigned ch, input bit rdy,
                            inout byte unsigned live[$], inout byte unsigned outq[$],
                            inout bit vld, output bit ovf, output bit busy);
    ovf  = 1'b0;
    busy = 1'b0;
    if (vld && rdy) vld = 1'b0;
    if (kp) begin
      if (ch == 8'h0A || ch == 8'h0D) begin
        if (!vld) begin
          outq = live;
          vld  = 1'b1;
          live.delete();
        end else begin
          busy = 1'b1;
        end
      end else if (ch == 8'h08) begin
        if (live.size() > 0) void'(live.pop_back());
      end else if (ch == 8'h1B) begin
        live.delete();
      end else if (ch >= 8'h20 && ch <= 8'h7E) begin
        if (live.size() < maxc) live.push_back(ch);
        else ovf = 1'b1;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_live_line"}, live_line, '0);
    chk({tag, "_live_len"}, 256'(live_len), '0);
    chk({tag, "_line_out"}, line_out, '0);
    chk({tag, "_line_len"}, 256'(line_len), '0);
    chk({tag, "_line_valid"}, 256'(line_valid), '0);
    chk({tag, "_overflow"}, 256'(overflow), '0);
    chk({tag, "_commit_busy"}, 256'(commit_busy), '0);
    chk({tag, "_live_line4"}, 256'(live_line4), '0);
    chk({tag, "_line_valid4"}, 256'(line_valid4), '0);
    chk({tag, "_line_out4"}, 256'(line_out4), '0);
  endtask

  byte unsigned m_live32[$], m_out32[$], m_live4[$], m_out4[$];
  bit m_vld32, m_vld4, m_ovf32, m_ovf4, m_busy32, m_busy4;

  initial begin
    resetn      = 1'b0;
    key_pressed = 1'b0;
    ascii_char  = 8'h00;
    line_ready  = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clock);
    resetn = 1'b1;

    // FIRE, BKSP edit, busy slot, same-cycle drain+commit, ESC, ignored codes, empty commit.
    tv.push_back(mk(1, "F",   0, 1, 32'h46000000, 0, 32'h00000000, 0, 0, 0));
    tv.push_back(mk(1, "I",   0, 2, 32'h46490000, 0, 32'h00000000, 0, 0, 0));
    tv.push_back(mk(1, "R",   0, 3, 32'h46495200, 0, 32'h00000000, 0, 0, 0));
    tv.push_back(mk(1, "E",   0, 4, 32'h46495245, 0, 32'h00000000, 0, 0, 0));
    tv.push_back(mk(1, 8'h0A, 0, 0, 32'h00000000, 4, 32'h46495245, 1, 0, 0));
    tv.push_back(mk(0, 8'h00, 1, 0, 32'h00000000, 4, 32'h46495245, 0, 0, 0));
    tv.push_back(mk(1, "A",   0, 1, 32'h41000000, 4, 32'h46495245, 0, 0, 0));
    tv.push_back(mk(1, "B",   0, 2, 32'h41420000, 4, 32'h46495245, 0, 0, 0));
    tv.push_back(mk(1, 8'h08, 0, 1, 32'h41000000, 4, 32'h46495245, 0, 0, 0));
    tv.push_back(mk(1, "C",   0, 2, 32'h41430000, 4, 32'h46495245, 0, 0, 0));
    tv.push_back(mk(1, 8'h0D, 0, 0, 32'h00000000, 2, 32'h41430000, 1, 0, 0));
    tv.push_back(mk(1, 8'h08, 0, 0, 32'h00000000, 2, 32'h41430000, 1, 0, 0));
    tv.push_back(mk(1, 8'h08, 0, 0, 32'h00000000, 2, 32'h41430000, 1, 0, 0));
    tv.push_back(mk(1, 8'h01, 0, 0, 32'h00000000, 2, 32'h41430000, 1, 0, 0));
    tv.push_back(mk(1, "B",   0, 1, 32'h42000000, 2, 32'h41430000, 1, 0, 0));
    tv.push_back(mk(1, 8'h0A, 0, 1, 32'h42000000, 2, 32'h41430000, 1, 0, 1));
    tv.push_back(mk(1, 8'h0A, 1, 0, 32'h00000000, 1, 32'h42000000, 1, 0, 0));
    tv.push_back(mk(0, 8'h00, 1, 0, 32'h00000000, 1, 32'h42000000, 0, 0, 0));
    tv.push_back(mk(1, "X",   0, 1, 32'h58000000, 1, 32'h42000000, 0, 0, 0));
    tv.push_back(mk(1, "Y",   0, 2, 32'h58590000, 1, 32'h42000000, 0, 0, 0));
    tv.push_back(mk(1, "Z",   0, 3, 32'h58595A00, 1, 32'h42000000, 0, 0, 0));
    tv.push_back(mk(1, 8'h1B, 0, 0, 32'h00000000, 1, 32'h42000000, 0, 0, 0));
    tv.push_back(mk(1, 8'h7F, 0, 0, 32'h00000000, 1, 32'h42000000, 0, 0, 0));
    tv.push_back(mk(1, 8'h1F, 0, 0, 32'h00000000, 1, 32'h42000000, 0, 0, 0));
    tv.push_back(mk(1, "~",   0, 1, 32'h7E000000, 1, 32'h42000000, 0, 0, 0));
    tv.push_back(mk(1, " ",   0, 2, 32'h7E200000, 1, 32'h42000000, 0, 0, 0));
    tv.push_back(mk(0, "A",   0, 2, 32'h7E200000, 1, 32'h42000000, 0, 0, 0));
    tv.push_back(mk(1, 8'h1B, 0, 0, 32'h00000000, 1, 32'h42000000, 0, 0, 0));
    tv.push_back(mk(1, 8'h0A, 0, 0, 32'h00000000, 0, 32'h00000000, 1, 0, 0));
    tv.push_back(mk(0, 8'h00, 1, 0, 32'h00000000, 0, 32'h00000000, 0, 0, 0));

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].kp, tv[i].ch, tv[i].rdy);
      chk($sformatf("v%0d_live_line", i), live_line, {tv[i].live_top, 224'b0});
      chk($sformatf("v%0d_live_len", i), 256'(live_len), 256'(tv[i].live_len));
      chk($sformatf("v%0d_line_out", i), line_out, {tv[i].out_top, 224'b0});
      chk($sformatf("v%0d_line_len", i), 256'(line_len), 256'(tv[i].line_len));
      chk($sformatf("v%0d_line_valid", i), 256'(line_valid), 256'(tv[i].vld));
      chk($sformatf("v%0d_overflow", i), 256'(overflow), 256'(tv[i].ovf));
      chk($sformatf("v%0d_commit_busy", i), 256'(commit_busy), 256'(tv[i].busy));
    end

    // Asynchronous reset mid-line with the slot full: must clear before the next edge.
    drive(1, "Q", 0);
    drive(1, 8'h0A, 0);
    drive(1, "R", 0);
    @(negedge clock);
    key_pressed = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clock);
    resetn = 1'b1;

    // Overflow on the small instance: ABCD fills it, E is dropped.
    drive(1, "A", 0);
    chk("ovf_A", 256'(overflow4), '0);
    drive(1, "B", 0);
    chk("ovf_B", 256'(overflow4), '0);
    drive(1, "C", 0);
    chk("ovf_C", 256'(overflow4), '0);
    drive(1, "D", 0);
    chk("ovf_D", 256'(overflow4), '0);
    drive(1, "E", 0);
    chk("ovf_E", 256'(overflow4), 256'(1));
    chk("ovf_live4", 256'(live_line4), 256'(32'h41424344));
    chk("ovf_len4", 256'(live_len4), 256'(4));
    drive(0, 8'h00, 0);
    chk("ovf_after", 256'(overflow4), '0);
    chk("ovf_live4_hold", 256'(live_line4), 256'(32'h41424344));

    // Randomized run on both instances against the queue model.
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    m_live32.delete(); m_out32.delete(); m_live4.delete(); m_out4.delete();
    m_vld32 = 1'b0; m_vld4 = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      bit           kp, rdy;
      byte unsigned ch;
      int unsigned  sel;
      kp  = ($urandom_range(0, 9) < 7);
      rdy = ((i % 1000) < 300) ? 1'b1 : 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 99);
      if (sel < 8)       ch = ($urandom_range(0, 1) != 0) ? 8'h0A : 8'h0D;
      else if (sel < 20) ch = 8'h08;
      else if (sel < 24) ch = 8'h1B;
      else if (sel < 30) ch = 8'($urandom_range(0, 255));
      else               ch = 8'($urandom_range(32'h20, 32'h7E));

      model_step(32, kp, ch, rdy, m_live32, m_out32, m_vld32, m_ovf32, m_busy32);
      model_step(4,  kp, ch, rdy, m_live4,  m_out4,  m_vld4,  m_ovf4,  m_busy4);
      drive(kp, ch, rdy);

      chk("rnd_live_line", live_line, pack(m_live32, 32));
      chk("rnd_live_len", 256'(live_len), 256'(m_live32.size()));
      chk("rnd_line_out", line_out, pack(m_out32, 32));
      chk("rnd_line_len", 256'(line_len), 256'(m_out32.size()));
      chk("rnd_line_valid", 256'(line_valid), 256'(m_vld32));
      chk("rnd_overflow", 256'(overflow), 256'(m_ovf32));
      chk("rnd_commit_busy", 256'(commit_busy), 256'(m_busy32));
      chk("rnd4_live_line", 256'(live_line4), pack(m_live4, 4));
      chk("rnd4_live_len", 256'(live_len4), 256'(m_live4.size()));
      chk("rnd4_line_out", 256'(line_out4), pack(m_out4, 4));
      chk("rnd4_line_len", 256'(line_len4), 256'(m_out4.size()));
      chk("rnd4_line_valid", 256'(line_valid4), 256'(m_vld4));
      chk("rnd4_overflow", 256'(overflow4), 256'(m_ovf4));
      chk("rnd4_commit_busy", 256'(commit_busy4), 256'(m_busy4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_line_editor.md
# ps2_line_editor

Parametrised keyboard line editor that sits between the PS/2 ASCII decoder and the command interpreter. It accumulates printable characters into a live line of configurable length. It implements true backspace (erase last character), escape-to-clear and overflow detection. On Enter it commits the line to a one-entry output slot drained by a valid/ready handshake. The live line feeds the VGA console echo; the committed line feeds the interpreter.

## Interface
- `MAX_CHARS`, 32: maximum characters per line (≥2).
- `CHAR_W`, 8: bits per character.
- `LEN_W`, $clog2(MAX_CHARS+1): width of length fields.
- `clock` in 1: system clock, all logic on posedge.
- `resetn` in 1: asynchronous, active-low reset.
- `key_pressed` in 1: one-cycle strobe, `ascii_char` valid.
- `ascii_char` in CHAR_W: decoded key code.
- `live_line` out MAX_CHARS*CHAR_W: line being edited. Char 0 sits in the MSBs; unused slots are 0.
- `live_len` out LEN_W: characters currently in `live_line`.
- `line_out` out MAX_CHARS*CHAR_W: committed line, same packing.
- `line_len` out LEN_W: length of committed line.
- `line_valid` out 1: committed line available.
- `line_ready` in 1: consumer accepts `line_out` when high with `line_valid`.
- `overflow` out 1: one-cycle pulse, printable char dropped because line full.
- `commit_busy` out 1: one-cycle pulse, Enter rejected because slot occupied.

## Operation
- Reset values: `live_line`, `line_out` = 0; `live_len`, `line_len` = 0; `line_valid`, `overflow`, `commit_busy` = 0.
- Key classes, evaluated only when `key_pressed` is high:
  - ENTER (0x0A or 0x0D)
  - BKSP (0x08)
  - ESC (0x1B)
  - PRINT (0x20–0x7E)
  - all other codes are ignored with no state change.
- PRINT with `live_len` < MAX_CHARS: write the char to slot `live_len`, then `live_len`+1.
- PRINT with `live_len` == MAX_CHARS: drop the char and pulse `overflow`.
- BKSP with `live_len` > 0: zero slot `live_len`-1, then `live_len`-1.
- BKSP with `live_len` == 0: no-op. There is no underflow or wrap.
- ESC: clear `live_line` to 0 and `live_len` to 0. The output slot is untouched.
- ENTER with the slot free, meaning `line_valid`=0 or a handshake completes this cycle:
  - copy `live_line` and `live_len` to `line_out` and `line_len`;
  - set `line_valid`;
  - clear the live line.
- ENTER on an empty line (`live_len`=0) still commits, with `line_len`=0. The interpreter treats this as a no-op command.
- ENTER with the slot occupied and no handshake this cycle: keep the live line unchanged and pulse `commit_busy`.
- Handshake: `line_valid & line_ready` at an edge clears `line_valid`. `line_out` holds its value until the next commit.
- Slot state machine:
  - EMPTY → FULL on accepted ENTER.
  - FULL → EMPTY on handshake without ENTER.
  - FULL → FULL on handshake plus ENTER in the same cycle; the new line is loaded.
- Reset asserted mid-line or with the slot FULL returns everything to reset values immediately. Nothing is committed.

## Timing
- Every key effect is visible on the outputs the cycle after the `key_pressed` edge. Latency is 1.
- `line_valid` rises 1 cycle after the ENTER strobe. `line_out` is stable whenever `line_valid` is high.
- `overflow` and `commit_busy` are high for exactly the one cycle following the offending strobe.
- Back-to-back strobes on consecutive cycles are each processed. There is no dead cycle.
- `line_ready` may be held high permanently. Each committed line is then valid for exactly one cycle.
- No combinational path from `line_ready` to `line_valid`.

## Structure
- Shared package `ps2_pkg` holds:
  - key-code constants `KEY_ENTER`, `KEY_CR`, `KEY_BKSP`, `KEY_ESC`, `PRINT_LO`, `PRINT_HI`;
  - the slot-state enum `{SLOT_EMPTY, SLOT_FULL}`.
- One sub-module, `ps2_key_classify`: combinational, maps `ascii_char` to a one-hot key class. It is reused by the interpreter.
- Slot writes use an indexed part-select `[(MAX_CHARS-1-idx)*CHAR_W +: CHAR_W]`. No per-index if-chains.

## Test plan
- Type "FIRE", then ENTER:
  - `live_len` goes 1,2,3,4;
  - after ENTER, `line_out` holds 0x46495245 in the top 32 bits with all lower bits 0, `line_len`=4, `line_valid`=1, `live_len`=0.
- Type "AB", BKSP, "C", ENTER: `line_len`=2 and top chars are 0x41,0x43. Two BKSPs on an empty line leave `live_len`=0.
- With MAX_CHARS=4, type "ABCDE":
  - `overflow` pulses once, on the E;
  - `live_line`=0x41424344.
- Commit "A", hold `line_ready`=0, type "B", ENTER:
  - `commit_busy` pulses and `live_line` keeps "B";
  - raise `line_ready`, re-ENTER: `line_out`="B".
- Slot FULL, `line_ready`=1 in the same cycle as the ENTER strobe: the new line loads and `line_valid` stays 1.
- Type "XYZ", pulse ESC: `live_len`=0. Then type "Q" and assert `resetn`=0 mid-line: all outputs return to 0 asynchronously, before the next clock edge.
